// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dpram_fifo_ctrl
// Description : Pointer/flag controller that wraps a 16x8 dual-port RAM
//               (separate write/read ports, 1-cycle registered read) into a
//               synchronous FIFO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous reset, active low
//   clr          : synchronous soft clear (pointers/valid cleared, errors kept)
//   push / pop   : producer write / consumer read requests
//   mem_write    : RAM write enable (push accepted this cycle)
//   mem_wr_addr  : RAM write address
//   mem_read     : RAM read enable (pop accepted this cycle)
//   mem_rd_addr  : RAM read address
//   rd_valid     : RAM data_out holds the popped entry this cycle
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow     : sticky, push while full
//   underflow    : sticky, pop while empty
// ============================================================================
module dpram_fifo_ctrl #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] c_AE_CNT    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] c_PTR_ONE   = (ADDR_W+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  // Occupancy is the modular pointer difference; count == DEPTH is the same
  // condition as "wrap bits differ, address bits equal".
  assign w_count = wr_ptr_q - rd_ptr_q;
  assign w_full  = (w_count == c_DEPTH_CNT);
  assign w_empty = (wr_ptr_q == rd_ptr_q);

  // Reset and clear both suppress RAM accesses in the cycle they are applied.
  assign w_push_ok = push & ~w_full  & ~clr & rst;
  assign w_pop_ok  = pop  & ~w_empty & ~clr & rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (w_push_ok) begin
        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      // RAM read is registered, so data_out is valid the cycle after the pop.
      rd_valid_d = w_pop_ok;
      if (push && w_full) begin
        overflow_d = 1'b1;
      end
      if (pop && w_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign mem_write    = w_push_ok;
  assign mem_read     = w_pop_ok;
  assign mem_wr_addr  = wr_ptr_q[ADDR_W-1:0];
  assign mem_rd_addr  = rd_ptr_q[ADDR_W-1:0];
  assign rd_valid     = rd_valid_q;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= c_AF_CNT);
  assign almost_empty = (w_count <= c_AE_CNT);
  assign count        = w_count;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpram_fifo_ctrl
// Description : Scoreboard bench for dpram_fifo_ctrl. A behavioural 16x8 RAM
//               is driven by the controller; stimulus queues expected write
//               addresses, read addresses and read data, and a monitor pops
//               and compares whenever the DUT strobes mem_write, mem_read or
//               rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, clr, push, pop;
  logic       mem_write, mem_read, rd_valid;
  logic [3:0] mem_wr_addr, mem_rd_addr;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic [7:0] ram [16];
  logic [7:0] din;
  logic [7:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_wr_q [$];
  logic [3:0] exp_rd_q [$];
  logic [7:0] exp_dat_q[$];
  logic [3:0] wr_model;
  logic [3:0] rd_model;
  logic [7:0] data_ctr;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DEPTH(16), .ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .mem_write(mem_write), .mem_wr_addr(mem_wr_addr),
    .mem_read(mem_read), .mem_rd_addr(mem_rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Behavioural dual-port RAM with 1-cycle registered read.
  always @(posedge clk) begin
    if (mem_write) ram[mem_wr_addr] <= din;
    if (mem_read)  dout <= ram[mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each DUT strobe against the front of its queue.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_wr_q.size() == 0) chk("unexpected_mem_write", 32'd1, 32'd0);
      else chk("mem_wr_addr", 32'(mem_wr_addr), 32'(exp_wr_q.pop_front()));
    end
    if (mem_read === 1'b1) begin
      if (exp_rd_q.size() == 0) chk("unexpected_mem_read", 32'd1, 32'd0);
      else chk("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_rd_q.pop_front()));
    end
    if (rd_valid === 1'b1) begin
      if (exp_dat_q.size() == 0) chk("unexpected_rd_valid", 32'd1, 32'd0);
      else chk("rd_data", 32'(dout), 32'(exp_dat_q.pop_front()));
    end
  end

  // Entered and left at 1 time unit after a rising edge. pacc/qacc are the
  // hand-determined acceptance outcomes for this cycle.
  task automatic do_cycle(input logic p, input logic q, input logic pacc, input logic qacc);
    push = p;
    pop  = q;
    din  = data_ctr;
    if (pacc) begin
      exp_wr_q.push_back(wr_model);
      exp_dat_q.push_back(data_ctr);
      wr_model = wr_model + 4'd1;
      data_ctr = data_ctr + 8'd1;
    end
    if (qacc) begin
      exp_rd_q.push_back(rd_model);
      rd_model = rd_model + 4'd1;
    end
    #1;
    chk("mem_write_accept", 32'(mem_write), 32'(pacc));
    chk("mem_read_accept",  32'(mem_read),  32'(qacc));
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_model = '0;
    rd_model = '0;
    data_ctr = 8'hA0;
    din  = '0;
    rst  = 1'b0;
    clr  = 1'b0;
    push = 1'b1;
    pop  = 1'b1;

    // Reset held two cycles with push/pop asserted.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read",  32'(mem_read),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_ae",        32'(almost_empty), 32'd1);
    chk("rst_af",        32'(almost_full),  32'd0);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;

    // Fill 16 from empty.
    for (int i = 1; i <= 16; i++) begin
      do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af",    32'(almost_full), 32'(i >= 12));
      chk("fill_full",  32'(full), 32'(i == 16));
    end
    // 17th push rejected.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_count",     32'(count),     32'd16);
    chk("ovf_overflow",  32'(overflow),  32'd1);
    chk("ovf_underflow", 32'(underflow), 32'd0);

    // Drain 16.
    for (int i = 1; i <= 16; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
      chk("drain_count",    32'(count), 32'(16 - i));
      chk("drain_ae",       32'(almost_empty), 32'((16 - i) <= 2));
      chk("drain_rd_valid", 32'(rd_valid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    // Extra pop rejected.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("unf_rd_valid",  32'(rd_valid),  32'd0);
    chk("unf_underflow", 32'(underflow), 32'd1);
    chk("unf_count",     32'(count),     32'd0);

    // Fill to 10, then 20 simultaneous push+pop cycles crossing the wrap.
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("wrap_fill_count", 32'(count), 32'd10);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("wrap_count",    32'(count),    32'd10);
      chk("wrap_rd_valid", 32'(rd_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset pulse clears sticky errors; models restart from address 0.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_model = '0;
    rd_model = '0;
    chk("rst2_overflow",  32'(overflow),  32'd0);
    chk("rst2_underflow", 32'(underflow), 32'd0);

    // At full: push+pop only pops.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("bf_full", 32'(full), 32'd1);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("bf_count",    32'(count),    32'd15);
    chk("bf_overflow", 32'(overflow), 32'd1);

    // At empty: push+pop only pushes, no bypass.
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("be_empty",          32'(empty),     32'd1);
    chk("be_underflow_pre",  32'(underflow), 32'd0);
    do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("be_count",     32'(count),     32'd1);
    chk("be_underflow", 32'(underflow), 32'd1);
    chk("be_rd_valid",  32'(rd_valid),  32'd0);

    // clr vs rst: reach count 7, clear with push/pop asserted.
    for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_pre_count", 32'(count), 32'd7);
    clr  = 1'b1;
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("clr_mem_write", 32'(mem_write), 32'd0);
    chk("clr_mem_read",  32'(mem_read),  32'd0);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    exp_dat_q.delete();
    wr_model = '0;
    rd_model = '0;
    chk("clr_count",     32'(count),     32'd0);
    chk("clr_empty",     32'(empty),     32'd1);
    chk("clr_rd_valid",  32'(rd_valid),  32'd0);
    chk("clr_overflow",  32'(overflow),  32'd1);
    chk("clr_underflow", 32'(underflow), 32'd1);
    // Pointers restart at address 0 after clear.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst3_overflow",  32'(overflow),  32'd0);
    chk("rst3_underflow", 32'(underflow), 32'd0);

    chk("left_wr_q",  32'(exp_wr_q.size()),  32'd0);
    chk("left_rd_q",  32'(exp_rd_q.size()),  32'd0);
    chk("left_dat_q", 32'(exp_dat_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
